// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode and FSM state encodings shared with decode
package alu_pkg;
  localparam logic [4:0] ALU_AND    = 5'b00000;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_SUB    = 5'b00011;
  localparam logic [4:0] ALU_SLL    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SRA    = 5'b00110;
  localparam logic [4:0] ALU_XOR    = 5'b00111;
  localparam logic [4:0] ALU_PASSB  = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_MULHU  = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_REMU   = 5'b10000;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: radix-2 restoring divider, one quotient bit per cycle, MSB first
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  input  logic             rem_op,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem, quo, dvs, rem_nx, quo_nx, a_abs, b_abs;
  logic [WIDTH:0] shifted, diff;
  logic [CW-1:0] cnt;
  logic active, neg_q, neg_r, rem_sel;
  always_comb begin
    a_abs = (signed_op && a[WIDTH-1]) ? -a : a;
    b_abs = (signed_op && b[WIDTH-1]) ? -b : b;
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    rem_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
    done = active && (&cnt);
    res = rem_sel ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= a_abs;
      dvs <= b_abs;
      neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= signed_op && a[WIDTH-1];
      rem_sel <= rem_op;
    end else if (active) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      active <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU with registered result and iterative divide
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  logic [1:0] state;
  logic [SHW-1:0] sh;
  logic [2*WIDTH-1:0] ma, mb, prod;
  logic [WIDTH-1:0] comb_res, div_res;
  logic is_div, signed_op, rem_op, b_zero, ovf, div_start, div_done;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == DIV;
  always_comb begin
    sh = b[SHW-1:0];
    ma = {(aluc == ALU_MULH || aluc == ALU_MULHSU) ? {WIDTH{a[WIDTH-1]}} : {WIDTH{1'b0}}, a};
    mb = {(aluc == ALU_MULH) ? {WIDTH{b[WIDTH-1]}} : {WIDTH{1'b0}}, b};
    prod = ma * mb;
    is_div = aluc >= ALU_DIV && aluc <= ALU_REMU;
    signed_op = aluc == ALU_DIV || aluc == ALU_REM;
    rem_op = aluc == ALU_REM || aluc == ALU_REMU;
    b_zero = b == '0;
    ovf = signed_op && a == {1'b1, {(WIDTH-1){1'b0}}} && (&b);
    div_start = in_valid && in_ready && is_div && !b_zero && !ovf;
    // Divide entries here only cover the divide-by-zero and overflow shortcuts
    case (aluc)
      ALU_AND:    comb_res = a & b;
      ALU_OR:     comb_res = a | b;
      ALU_ADD:    comb_res = a + b;
      ALU_SUB:    comb_res = a - b;
      ALU_SLL:    comb_res = a << sh;
      ALU_SRL:    comb_res = a >> sh;
      ALU_SRA:    comb_res = $signed(a) >>> sh;
      ALU_XOR:    comb_res = a ^ b;
      ALU_PASSB:  comb_res = b;
      ALU_MUL:    comb_res = prod[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: comb_res = prod[2*WIDTH-1:WIDTH];
      ALU_DIV:    comb_res = b_zero ? '1 : a;
      ALU_DIVU:   comb_res = '1;
      ALU_REM:    comb_res = b_zero ? a : '0;
      ALU_REMU:   comb_res = a;
      default:    comb_res = '0;
    endcase
  end
  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst_n(rst_n), .start(div_start), .a(a), .b(b),
    .signed_op(signed_op), .rem_op(rem_op), .done(div_done), .res(div_res)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= div_start ? DIV : DONE;
          if (!div_start) result <= comb_res;
        end
        DIV: if (div_done) begin
          state <= DONE;
          result <= div_res;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Handshaked multi-cycle ALU, the parametrised successor of the combinational execute-stage ALU.
- Width is generic. Adds a registered result with valid/ready handshakes, MULHSU, true signed/unsigned division and remainder (radix-2 restoring, iterative), and RISC-V divide-by-zero and overflow semantics.
- Sits between decode/issue and writeback; one operation in flight.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- aluc  in  5  operation select.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result; stable while out_valid and !out_ready.
- busy  out  1  high in DIV state.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 next cycle. Reset wins over every other event, including mid-division; the in-flight op is discarded with no output.
- Accept when in_valid && in_ready. a, b and aluc are captured; later input changes are ignored.
- Opcodes (aluc):
  - 00000 AND; 00001 OR; 00010 ADD; 00011 SUB (modulo 2^WIDTH).
  - 00100 SLL, 00101 SRL, 00110 SRA: amount = b[SHW-1:0].
  - 00111 XOR; 01000 PASSB.
  - 01001 MUL: low WIDTH bits.
  - 01010 MULH: signed x signed, high half.
  - 01011 MULHSU: signed a x unsigned b, high half.
  - 01100 MULHU: unsigned x unsigned, high half.
  - 01101 DIV, 01110 DIVU, 01111 REM, 10000 REMU.
  - All other codes: result 0.
- FSM states:
  - IDLE: on accept, non-divide ops and divide special cases go to DONE, with result loaded at the same edge (latency 1). Normal divides go to DIV.
  - DIV: WIDTH iterations, one quotient bit per cycle, MSB first. Operands are absolute values; signs are fixed on exit. Then go to DONE, result loaded on the final iteration edge. Latency from accept edge to out_valid = WIDTH+1 cycles.
  - DONE: out_valid=1. On out_ready, go to IDLE (out_valid=0 next cycle). Back-to-back ops therefore need at least one IDLE cycle.
- Divide rules:
  - Quotient rounds toward zero. Remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a. Latency 1.
  - Signed overflow (a = most negative, b = -1): DIV returns a, REM returns 0. Latency 1.
- out_valid held with out_ready low: result and out_valid stay constant indefinitely.
- in_valid while not in IDLE: ignored (in_ready=0), no side effects.

Decomposition:
- Package alu_pkg: 5-bit opcode localparams (ALU_AND ... ALU_REMU) and state encoding (IDLE, DIV, DONE), shared with decode.
- Sub-module alu_div_iter: operand load, iteration counter, remainder/quotient shift registers, sign fix, done pulse. Parent holds FSM, handshakes and combinational ops.

Test Plan:
- All test values below use WIDTH=32.
- DIVU a=100, b=7 -> result 14 with out_valid exactly 33 cycles after accept. REMU same operands -> 2.
- REM a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, latency 1. DIVU a=5, b=0 -> 0xFFFFFFFF. REM a=5, b=0 -> 5.
- MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULHU same operands -> 0x00000001. SRA a=0x80000000, b=0x24 -> 0xF8000000 (amount 4).
- Backpressure: ADD 3+4 with out_ready=0 for 10 cycles -> result 7, out_valid held, in_ready=0 throughout. in_valid pulses in that window are not accepted.
- Reset mid-DIV: rst_n=0 at iteration 10 -> next cycle out_valid=0, result=0, busy=0. A subsequent ADD 1+1 -> 2 with latency 1.
